// File: rtl/glitch_cmd_parser.sv
// glitch_cmd_parser: host command decoder with length-prefixed passthrough FIFO; GLITCHER_CMD_ACK_EN adds ack_data/ack_valid
module glitch_cmd_parser #(
  parameter int         PASS_DEPTH  = 16,
  parameter int         TIMEOUT_CYC = 120000,
  parameter logic [7:0] WIDTH_RST   = 8'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  pass_data,
  output logic        pass_valid,
  input  logic        pass_rdy,
  output logic [7:0]  cfg_width,
  output logic [7:0]  cfg_pulses,
  output logic [31:0] cfg_delay,
  output logic        sys_rst_req,
  output logic        board_rst_req,
  output logic        glitch_arm,
  output logic        err
`ifdef GLITCHER_CMD_ACK_EN
  ,
  output logic [7:0]  ack_data,
  output logic        ack_valid
`endif
);
  localparam int AW = $clog2(PASS_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, CMD, ARG, PASS} state_t;
  state_t          state;
  logic [2:0]      tgt;
  logic [7:0]      cnt;
  logic [TW-1:0]   tmo;
  logic [7:0]      mem [PASS_DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [AW:0]     occ;
  logic            tmo_hit, full, pop, push_req, push, ovf, in_cmd, strobe_cmd, arg_cmd, bad_cmd;
  assign tmo_hit    = state != IDLE && !rx_valid && tmo == TW'(TIMEOUT_CYC - 1);
  assign full       = occ == (AW+1)'(PASS_DEPTH);
  assign pass_valid = occ != '0;
  assign pass_data  = mem[rp];
  assign pop        = pass_valid && pass_rdy;
  assign push_req   = state == PASS && rx_valid;
  assign push       = push_req && (!full || pop);
  assign ovf        = push_req && full && !pop;
  assign in_cmd     = state == CMD && rx_valid;
  assign strobe_cmd = in_cmd && rx_data inside {8'hFF, 8'hFE, 8'hFC};
  assign arg_cmd    = in_cmd && rx_data inside {8'h10, 8'h11, [8'h20:8'h23]};
  assign bad_cmd    = in_cmd && !strobe_cmd && !arg_cmd;
  // frame FSM, idle timeout, config registers and registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tgt           <= '0;
      cnt           <= '0;
      tmo           <= '0;
      cfg_width     <= WIDTH_RST;
      cfg_pulses    <= '0;
      cfg_delay     <= '0;
      sys_rst_req   <= 1'b0;
      board_rst_req <= 1'b0;
      glitch_arm    <= 1'b0;
      err           <= 1'b0;
    end else begin
      sys_rst_req   <= in_cmd && rx_data == 8'hFF;
      board_rst_req <= in_cmd && rx_data == 8'hFE;
      glitch_arm    <= in_cmd && rx_data == 8'hFC;
      err           <= bad_cmd || tmo_hit || ovf;
      tmo           <= (rx_valid || state == IDLE || tmo_hit) ? '0 : tmo + 1'b1;
      if (tmo_hit)
        state <= IDLE;
      else if (rx_valid)
        case (state)
          IDLE: begin
            state <= rx_data == 8'h00 ? CMD : PASS;
            cnt   <= rx_data;
          end
          CMD: begin
            state <= arg_cmd ? ARG : IDLE;
            tgt   <= rx_data[5] ? {1'b1, rx_data[1:0]} : {2'b00, rx_data[0]};
          end
          ARG: begin
            state <= IDLE;
            if (tgt == 3'd0) cfg_width <= rx_data;
            else if (tgt == 3'd1) cfg_pulses <= rx_data;
            else cfg_delay[{tgt[1:0], 3'b000} +: 8] <= rx_data;
          end
          PASS: begin
            cnt   <= cnt - 1'b1;
            state <= cnt == 8'd1 ? IDLE : PASS;
          end
          default: state <= IDLE;
        endcase
    end
  end
  // passthrough FIFO pointers and occupancy; a full FIFO still accepts a byte when it pops that cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else begin
      wp  <= push ? wp + 1'b1 : wp;
      rp  <= pop ? rp + 1'b1 : rp;
      occ <= occ + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  // FIFO storage, no reset needed since pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= rx_data;
  end
`ifdef GLITCHER_CMD_ACK_EN
  logic done;
  assign done = strobe_cmd || (state == ARG && rx_valid);
  // ack byte: 0xA5 for a completed command or write, 0x5A for unknown command or timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_valid <= 1'b0;
      ack_data  <= '0;
    end else begin
      ack_valid <= done || bad_cmd || tmo_hit;
      ack_data  <= done ? 8'hA5 : 8'h5A;
    end
  end
`endif
endmodule

// File: tb/tb_glitch_cmd_parser.sv
// tb_glitch_cmd_parser: scoreboard bench with directed cases and randomized command/passthrough traffic
module tb_glitch_cmd_parser;
  localparam int TMO = 40;
  typedef struct {int due; logic [47:0] v;} cfg_t;
  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0, pass_rdy = 1'b0;
  logic [7:0]  pass_data, cfg_width, cfg_pulses;
  logic        pass_valid, sys_rst_req, board_rst_req, glitch_arm, err;
  logic [31:0] cfg_delay;
`ifdef GLITCHER_CMD_ACK_EN
  logic [7:0]  ack_data;
  logic        ack_valid;
`endif
  logic [7:0]  byte_q[$], ack_q[$];
  logic [3:0]  ev_q[$];
  cfg_t        cfg_q[$];
  cfg_t        mc;
  logic [7:0]  m_w = 8'd1, m_p = '0;
  logic [31:0] m_d = '0;
  logic [3:0]  ev, ev_exp;
  logic [7:0]  b_exp;
  int          cyc = 0, n_pass = 0, n_tot = 0, rdy_mode = 0;

  glitch_cmd_parser #(.PASS_DEPTH(16), .TIMEOUT_CYC(TMO), .WIDTH_RST(8'd1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .pass_data(pass_data), .pass_valid(pass_valid), .pass_rdy(pass_rdy),
    .cfg_width(cfg_width), .cfg_pulses(cfg_pulses), .cfg_delay(cfg_delay),
    .sys_rst_req(sys_rst_req), .board_rst_req(board_rst_req), .glitch_arm(glitch_arm), .err(err)
`ifdef GLITCHER_CMD_ACK_EN
    , .ack_data(ack_data), .ack_valid(ack_valid)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a byte, strobe, ack or due config
  always @(negedge clk) begin
    if (!rst) begin
      if (pass_valid && pass_rdy) begin
        b_exp = byte_q.size() != 0 ? byte_q.pop_front() : 8'hxx;
        chk(pass_data === b_exp, "pass_data", 48'(pass_data), 48'(b_exp));
      end
      ev = {err, glitch_arm, board_rst_req, sys_rst_req};
      if (ev != 4'd0) begin
        ev_exp = ev_q.size() != 0 ? ev_q.pop_front() : 4'd0;
        chk(ev == ev_exp, "strobe {err,arm,board,sys}", 48'(ev), 48'(ev_exp));
      end
`ifdef GLITCHER_CMD_ACK_EN
      if (ack_valid) begin
        b_exp = ack_q.size() != 0 ? ack_q.pop_front() : 8'hxx;
        chk(ack_data === b_exp, "ack_data", 48'(ack_data), 48'(b_exp));
      end
`endif
      while (cfg_q.size() != 0 && cfg_q[0].due <= cyc) begin
        mc = cfg_q.pop_front();
        chk({cfg_width, cfg_pulses, cfg_delay} == mc.v, "cfg {w,p,d}", {cfg_width, cfg_pulses, cfg_delay}, mc.v);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      pass_rdy = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : rdy_mode[0];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic snap();
    cfg_q.push_back('{cyc + 1, {m_w, m_p, m_d}});
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_data = b; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(gap);
  endtask

  task automatic sp(input logic [7:0] b, input int gap);
    byte_q.push_back(b);
    send(b, gap);
  endtask

  function automatic bit known(input logic [7:0] c);
    return c inside {8'hFF, 8'hFE, 8'hFC, 8'h10, 8'h11, 8'h20, 8'h21, 8'h22, 8'h23};
  endfunction

  // a strobe command or an unknown command byte after the escape
  task automatic cmd(input logic [7:0] c, input int gap);
    send(8'h00, gap);
    ev_q.push_back(c == 8'hFF ? 4'd1 : c == 8'hFE ? 4'd2 : c == 8'hFC ? 4'd4 : 4'd8);
    ack_q.push_back(c inside {8'hFF, 8'hFE, 8'hFC} ? 8'hA5 : 8'h5A);
    snap();
    send(c, gap);
  endtask

  task automatic wr(input logic [7:0] c, input logic [7:0] a, input int gap);
    send(8'h00, gap);
    send(c, gap);
    if (c == 8'h10) m_w = a;
    else if (c == 8'h11) m_p = a;
    else m_d[{c[1:0], 3'b000} +: 8] = a;
    ack_q.push_back(8'hA5);
    snap();
    send(a, gap);
  endtask

  task automatic drain();
    int n = 0;
    while (byte_q.size() != 0 && n < 3000) begin tick(1); n++; end
    chk(byte_q.size() == 0, "drain bytes left", 48'(byte_q.size()), 48'd0);
    tick(3);
  endtask

  task automatic rst_chk();
    chk(pass_valid == 1'b0, "rst pass_valid", 48'(pass_valid), 48'd0);
    chk(cfg_width == 8'd1, "rst cfg_width", 48'(cfg_width), 48'd1);
    chk(cfg_pulses == 8'd0, "rst cfg_pulses", 48'(cfg_pulses), 48'd0);
    chk(cfg_delay == 32'd0, "rst cfg_delay", 48'(cfg_delay), 48'd0);
    chk({sys_rst_req, board_rst_req, glitch_arm, err} == 4'd0, "rst strobes",
        48'({sys_rst_req, board_rst_req, glitch_arm, err}), 48'd0);
  endtask

  initial begin
    logic [7:0] tg [6];
    logic [7:0] c;
    string s;
    tg = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h22, 8'h23};
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    rst_chk();
    tick(1);
    rdy_mode = 1;
    cmd(8'hFF, 0); cmd(8'hFE, 0); cmd(8'hFC, 0);
    wr(8'h10, 8'h02, 0); wr(8'h11, 8'h00, 0); wr(8'h20, 8'hC8, 0); wr(8'h23, 8'h01, 0);
    @(negedge clk);
    chk(cfg_width == 8'h02, "cfg_width 0x02", 48'(cfg_width), 48'h02);
    chk(cfg_pulses == 8'h00, "cfg_pulses 0x00", 48'(cfg_pulses), 48'h00);
    chk(cfg_delay == 32'h010000C8, "cfg_delay", 48'(cfg_delay), 48'h010000C8);
    tick(1);
    send(8'h01, 0); sp(8'h3F, 0);
    s = "Synchronized\r\n";
    send(8'(s.len()), 0);
    for (int i = 0; i < s.len(); i++) sp(s[i], 0);
    drain();
    rdy_mode = 0;
    tick(3);
    send(8'h14, 0);
    for (int i = 0; i < 20; i++) begin
      c = 8'($urandom);
      if (i < 16) byte_q.push_back(c);
      else ev_q.push_back(4'd8);
      send(c, 0);
    end
    @(negedge clk);
    chk(pass_valid == 1'b1, "full fifo pass_valid", 48'(pass_valid), 48'd1);
    tick(1);
    rdy_mode = 1;
    drain();
    cmd(8'h7B, 0);
    send(8'h00, 0);
    ev_q.push_back(4'd8); ack_q.push_back(8'h5A);
    send(8'h10, 0);
    tick(TMO + 5);
    snap();
    send(8'h01, 0); sp(8'h41, 0);
    drain();
    rdy_mode = 0;
    tick(3);
    send(8'h05, 0); sp(8'hAA, 0); sp(8'hBB, 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    byte_q.delete();
    m_w = 8'd1; m_p = 8'd0; m_d = 32'd0;
    @(negedge clk);
    rst_chk();
    tick(1);
    cmd(8'hFE, 0);
    rdy_mode = 2;
    repeat (80) begin
      case ($urandom_range(0, 3))
        0: cmd($urandom_range(0, 2) == 0 ? 8'hFF : $urandom_range(0, 1) ? 8'hFE : 8'hFC, $urandom_range(0, 3));
        1: wr(tg[$urandom_range(0, 5)], 8'($urandom), $urandom_range(0, 3));
        2: begin
          do c = 8'($urandom); while (known(c));
          cmd(c, $urandom_range(0, 3));
        end
        default: begin
          int n;
          drain();
          n = $urandom_range(1, 16);
          send(8'(n), $urandom_range(0, 2));
          for (int i = 0; i < n; i++) sp(8'($urandom), $urandom_range(0, 2));
        end
      endcase
    end
    rdy_mode = 1;
    drain();
    tick(5);
    chk(ev_q.size() == 0, "strobes never seen", 48'(ev_q.size()), 48'd0);
    chk(cfg_q.size() == 0, "cfg checks pending", 48'(cfg_q.size()), 48'd0);
`ifdef GLITCHER_CMD_ACK_EN
    chk(ack_q.size() == 0, "acks never seen", 48'(ack_q.size()), 48'd0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
